// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Operand forwarding and hazard control for the integer pipeline.
//   Each EXE source operand is steered to the nearest in-flight producer
//   (stage 0 = MEM first) or to the multi-cycle unit result. Load-use and
//   multi-cycle RAW/structural hazards seen in ID raise stall_id/flush_exe.
//   One scoreboard entry tracks the outstanding multi-cycle operation.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   id_src_addr      ID source addresses (source 0 in LSBs)
//   id_src_valid     ID source actually read
//   id_long_req      ID instruction is a multi-cycle op
//   exe_src_addr     EXE source addresses
//   exe_mem_read     EXE instruction is a load
//   exe_rd_addr      EXE destination
//   long_issue       multi-cycle op enters the unit this cycle
//   long_rd_addr     destination of that op
//   stage_reg_write  stage k writes the register file
//   stage_rd_addr    stage k destination
//   forward_src      per operand: 0 = regfile, k+1 = stage k, STAGE_N+1 = unit
//   stall_id         hold PC and IF/ID
//   flush_exe        bubble into ID/EXE
//   long_busy        scoreboard entry occupied (registered)
//
// Handshake: long_issue is a single-cycle strobe accepted when the entry is
// free or finishing (count==0); a strobe while count>0 is ignored because
// the structural stall keeps a second multi-cycle op out of EXE.
module hazard_forward_unit #(
  parameter int SRC_N      = 2,
  parameter int STAGE_N    = 2,
  parameter int ADDR_W     = 5,
  parameter int LONG_LAT   = 4,
  parameter int ZERO_GUARD = 1,
  localparam int SEL_W     = $clog2(STAGE_N + 2)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SRC_N*ADDR_W-1:0]   id_src_addr,
  input  logic [SRC_N-1:0]          id_src_valid,
  input  logic                      id_long_req,
  input  logic [SRC_N*ADDR_W-1:0]   exe_src_addr,
  input  logic                      exe_mem_read,
  input  logic [ADDR_W-1:0]         exe_rd_addr,
  input  logic                      long_issue,
  input  logic [ADDR_W-1:0]         long_rd_addr,
  input  logic [STAGE_N-1:0]        stage_reg_write,
  input  logic [STAGE_N*ADDR_W-1:0] stage_rd_addr,
  output logic [SRC_N*SEL_W-1:0]    forward_src,
  output logic                      stall_id,
  output logic                      flush_exe,
  output logic                      long_busy
);

  localparam int CNT_W = $clog2(LONG_LAT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   count, count_nx;
  logic [ADDR_W-1:0]  pend_rd, pend_nx;

  logic               long_result;  // result valid this cycle (count==0)
  logic               long_wait;    // result still in flight (count>0)
  logic               long_struct;  // unit not free in time for an ID op
  logic               load_use;
  logic               long_raw;
  logic [SEL_W-1:0]   fwd_sel [SRC_N];

  function automatic logic addr_match(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
    return (a == b) && ((ZERO_GUARD == 0) || (a != '0));
  endfunction

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      pend_rd <= '0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      pend_rd <= pend_nx;
    end
  end

  // Scoreboard next state
  always_comb begin
    state_nx = state;
    count_nx = count;
    pend_nx  = pend_rd;
    case (state)
      IDLE: begin
        if (long_issue) begin
          state_nx = BUSY;
          count_nx = CNT_W'(LONG_LAT - 1);
          pend_nx  = long_rd_addr;
        end
      end
      BUSY: begin
        if (count != '0) begin
          count_nx = count - 1'b1;
        end else if (long_issue) begin
          // back-to-back: the finishing entry is reloaded in place
          count_nx = CNT_W'(LONG_LAT - 1);
          pend_nx  = long_rd_addr;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign long_result = (state == BUSY) && (count == '0);
  assign long_wait   = (state == BUSY) && (count != '0);
  // At count==1 the ID op reaches EXE exactly as the entry frees, so only
  // count>1 blocks it.
  assign long_struct = (state == BUSY) && (count > CNT_W'(1));

  // Forward select: descending scan so the lowest (nearest) stage wins.
  always_comb begin
    for (int i = 0; i < SRC_N; i++) begin
      fwd_sel[i] = '0;
      for (int k = STAGE_N - 1; k >= 0; k--) begin
        if (stage_reg_write[k] &&
            addr_match(exe_src_addr[i*ADDR_W +: ADDR_W], stage_rd_addr[k*ADDR_W +: ADDR_W]))
          fwd_sel[i] = SEL_W'(k + 1);
      end
      if ((fwd_sel[i] == '0) && long_result &&
          addr_match(exe_src_addr[i*ADDR_W +: ADDR_W], pend_rd))
        fwd_sel[i] = SEL_W'(STAGE_N + 1);
    end
  end

  // ID-side hazard detection
  always_comb begin
    load_use = 1'b0;
    long_raw = 1'b0;
    for (int i = 0; i < SRC_N; i++) begin
      if (id_src_valid[i] && exe_mem_read &&
          addr_match(id_src_addr[i*ADDR_W +: ADDR_W], exe_rd_addr))
        load_use = 1'b1;
      if (id_src_valid[i] && long_wait &&
          addr_match(id_src_addr[i*ADDR_W +: ADDR_W], pend_rd))
        long_raw = 1'b1;
    end
  end

  // Outputs are all held at zero while reset is asserted.
  always_comb begin
    forward_src = '0;
    if (rst_n) begin
      for (int i = 0; i < SRC_N; i++)
        forward_src[i*SEL_W +: SEL_W] = fwd_sel[i];
    end
  end

  assign stall_id  = rst_n && (load_use || long_raw || (id_long_req && long_struct));
  assign flush_exe = stall_id;
  assign long_busy = rst_n && (state == BUSY);

endmodule
